// File: rtl/cache_stats_window.sv
// cache_stats_window
// Classifies L1/L2 hit/miss strobes, counts L1 hits, L2 hits and L2 misses over a
// window of WINDOW accesses, then computes AMAT x100 with a 40-step restoring divider.
// Each window result is presented on a valid/ready port. A window that closes while a
// previous result is still in flight is discarded and flagged in stat_dropped (sticky).
// Optional feature macro: CACHE_STATS_LIFETIME_EN adds 32-bit saturating lifetime
// counters life_l1_hits / life_l2_hits / life_l2_misses.
module cache_stats_window #(
   parameter int WINDOW  = 256,
   parameter int CNT_W   = 16,
   parameter int L1_LAT  = 1,
   parameter int L2_LAT  = 10,
   parameter int MEM_LAT = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             hit_l1,
   input  logic             miss_l1,
   input  logic             hit_l2,
   input  logic             miss_l2,
   output logic             stat_valid,
   input  logic             stat_ready,
   output logic [CNT_W-1:0] stat_l1_hits,
   output logic [CNT_W-1:0] stat_l2_hits,
   output logic [CNT_W-1:0] stat_l2_misses,
   output logic [23:0]      stat_amat_x100,
   output logic             stat_dropped,
   output logic             busy
`ifdef CACHE_STATS_LIFETIME_EN
   ,
   output logic [31:0]      life_l1_hits,
   output logic [31:0]      life_l2_hits,
   output logic [31:0]      life_l2_misses
`endif
);

   localparam logic [CNT_W-1:0] WIN_M1 = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DIV  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] acc_q, l1h_q, l2h_q, l2m_q;
   logic [CNT_W-1:0] snap_l1h_q, snap_l2h_q, snap_l2m_q;
   logic             pend_q;
   logic [5:0]       div_cnt_q;
   logic [39:0]      dvd_q;
   logic [CNT_W-1:0] rem_q;
   logic [38:0]      quo_q;
   logic [CNT_W-1:0] stat_l1_q, stat_l2h_q, stat_l2m_q;
   logic [23:0]      amat_q;
   logic             dropped_q;

   logic             is_l1_s, is_l2h_s, is_l2m_s, is_acc_s, win_close_s;
   logic             calc_s, step_s, done_s;
   logic [39:0]      total_s, dividend_s, quo_nx_s;
   logic [CNT_W:0]   rem_sh_s;
   logic [CNT_W-1:0] rem_nx_s;
   logic             q_bit_s;
   logic [23:0]      amat_s;

   // Classify the strobes of this cycle in priority order.
   always_comb begin
      is_l1_s  = 1'b0;
      is_l2h_s = 1'b0;
      is_l2m_s = 1'b0;
      if (hit_l1) begin
         is_l1_s = 1'b1;
      end else if (miss_l1 && hit_l2) begin
         is_l2h_s = 1'b1;
      end else if (miss_l1 && miss_l2) begin
         is_l2m_s = 1'b1;
      end else begin
         is_l1_s = 1'b0;
      end
   end

   assign is_acc_s    = is_l1_s | is_l2h_s | is_l2m_s;
   assign win_close_s = is_acc_s && (acc_q == WIN_M1);

   // Window counters: count classified accesses, restart from zero when a window closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0; l1h_q <= '0; l2h_q <= '0; l2m_q <= '0;
      end else if (clear || win_close_s) begin
         acc_q <= '0; l1h_q <= '0; l2h_q <= '0; l2m_q <= '0;
      end else if (is_acc_s) begin
         acc_q <= acc_q + CNT_W'(1'b1);
         l1h_q <= l1h_q + CNT_W'(is_l1_s);
         l2h_q <= l2h_q + CNT_W'(is_l2h_s);
         l2m_q <= l2m_q + CNT_W'(is_l2m_s);
      end
   end

   // Snapshot the closing window (including the closing access) when the FSM can take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         snap_l1h_q <= '0; snap_l2h_q <= '0; snap_l2m_q <= '0;
      end else if (clear) begin
         pend_q <= 1'b0;
         snap_l1h_q <= '0; snap_l2h_q <= '0; snap_l2m_q <= '0;
      end else begin
         pend_q <= win_close_s && (state_q == S_IDLE);
         if (win_close_s && (state_q == S_IDLE)) begin
            snap_l1h_q <= l1h_q + CNT_W'(is_l1_s);
            snap_l2h_q <= l2h_q + CNT_W'(is_l2h_s);
            snap_l2m_q <= l2m_q + CNT_W'(is_l2m_s);
         end
      end
   end

   // Sticky flag: a window closed while a previous result was still being processed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dropped_q <= 1'b0;
      end else if (clear) begin
         dropped_q <= 1'b0;
      end else if (win_close_s && (state_q != S_IDLE)) begin
         dropped_q <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else if (clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pend_q) state_d = S_CALC; else state_d = S_IDLE;
         S_CALC:  state_d = S_DIV;
         S_DIV:   if (div_cnt_q == 6'd39) state_d = S_OUT; else state_d = S_DIV;
         S_OUT:   if (stat_ready) state_d = S_IDLE; else state_d = S_OUT;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs and datapath controls, decoded from the state register only.
   always_comb begin
      busy       = (state_q != S_IDLE);
      stat_valid = (state_q == S_OUT);
      calc_s     = (state_q == S_CALC);
      step_s     = (state_q == S_DIV);
      done_s     = (state_q == S_DIV) && (div_cnt_q == 6'd39);
   end

   // Weighted cycle total of the snapshot and one restoring-divide step.
   always_comb begin
      total_s    = 40'(WINDOW) * 40'(L1_LAT)
                 + (40'(snap_l2h_q) + 40'(snap_l2m_q)) * 40'(L2_LAT)
                 + 40'(snap_l2m_q) * 40'(MEM_LAT);
      dividend_s = total_s * 40'd100;
      rem_sh_s   = {rem_q, dvd_q[39]};
      if (rem_sh_s >= {1'b0, WIN_C}) begin
         q_bit_s  = 1'b1;
         rem_nx_s = rem_sh_s[CNT_W-1:0] - WIN_C;
      end else begin
         q_bit_s  = 1'b0;
         rem_nx_s = rem_sh_s[CNT_W-1:0];
      end
      quo_nx_s = {quo_q, q_bit_s};
      if (|quo_nx_s[39:24]) begin
         amat_s = 24'hFFFFFF;
      end else begin
         amat_s = quo_nx_s[23:0];
      end
   end

   // Divider registers: load the dividend in CALC, shift one quotient bit per DIV cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q <= '0; rem_q <= '0; quo_q <= '0; div_cnt_q <= 6'd0;
      end else if (clear) begin
         dvd_q <= '0; rem_q <= '0; quo_q <= '0; div_cnt_q <= 6'd0;
      end else if (calc_s) begin
         dvd_q <= dividend_s; rem_q <= '0; quo_q <= '0; div_cnt_q <= 6'd0;
      end else if (step_s) begin
         dvd_q     <= {dvd_q[38:0], 1'b0};
         rem_q     <= rem_nx_s;
         quo_q     <= quo_nx_s[38:0];
         div_cnt_q <= div_cnt_q + 6'd1;
      end
   end

   // Result registers: counts load in CALC, AMAT loads on the last divide step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_l1_q <= '0; stat_l2h_q <= '0; stat_l2m_q <= '0; amat_q <= 24'd0;
      end else if (clear) begin
         stat_l1_q <= '0; stat_l2h_q <= '0; stat_l2m_q <= '0; amat_q <= 24'd0;
      end else begin
         if (calc_s) begin
            stat_l1_q  <= snap_l1h_q;
            stat_l2h_q <= snap_l2h_q;
            stat_l2m_q <= snap_l2m_q;
         end
         if (done_s) begin
            amat_q <= amat_s;
         end
      end
   end

   assign stat_l1_hits   = stat_l1_q;
   assign stat_l2_hits   = stat_l2h_q;
   assign stat_l2_misses = stat_l2m_q;
   assign stat_amat_x100 = amat_q;
   assign stat_dropped   = dropped_q;

`ifdef CACHE_STATS_LIFETIME_EN
   logic [31:0] life_l1_q, life_l2h_q, life_l2m_q;

   // Lifetime counters: saturating, untouched by window closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         life_l1_q <= 32'd0; life_l2h_q <= 32'd0; life_l2m_q <= 32'd0;
      end else if (clear) begin
         life_l1_q <= 32'd0; life_l2h_q <= 32'd0; life_l2m_q <= 32'd0;
      end else begin
         if (is_l1_s && (life_l1_q != 32'hFFFFFFFF))   life_l1_q  <= life_l1_q + 32'd1;
         if (is_l2h_s && (life_l2h_q != 32'hFFFFFFFF)) life_l2h_q <= life_l2h_q + 32'd1;
         if (is_l2m_s && (life_l2m_q != 32'hFFFFFFFF)) life_l2m_q <= life_l2m_q + 32'd1;
      end
   end

   assign life_l1_hits   = life_l1_q;
   assign life_l2_hits   = life_l2h_q;
   assign life_l2_misses = life_l2m_q;
`endif

endmodule

// File: tb/tb_cache_stats_window.sv
// Bench for cache_stats_window with WINDOW=8 and default latencies.
// A window-level model predicts stat_valid / stat_dropped / result fields every cycle;
// directed tests add hand-computed literal expectations.
module tb_cache_stats_window;
   localparam int WIN = 8;
   localparam int CW  = 16;

   logic          clk = 1'b0;
   logic          rst_n, clear, hit_l1, miss_l1, hit_l2, miss_l2, stat_ready;
   logic          stat_valid, stat_dropped, busy;
   logic [CW-1:0] stat_l1_hits, stat_l2_hits, stat_l2_misses;
   logic [23:0]   stat_amat_x100;
`ifdef CACHE_STATS_LIFETIME_EN
   logic [31:0]   life_l1_hits, life_l2_hits, life_l2_misses;
`endif

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   cache_stats_window #(.WINDOW(WIN), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .hit_l1(hit_l1), .miss_l1(miss_l1), .hit_l2(hit_l2), .miss_l2(miss_l2),
      .stat_valid(stat_valid), .stat_ready(stat_ready),
      .stat_l1_hits(stat_l1_hits), .stat_l2_hits(stat_l2_hits),
      .stat_l2_misses(stat_l2_misses), .stat_amat_x100(stat_amat_x100),
      .stat_dropped(stat_dropped), .busy(busy)
`ifdef CACHE_STATS_LIFETIME_EN
      , .life_l1_hits(life_l1_hits), .life_l2_hits(life_l2_hits),
      .life_l2_misses(life_l2_misses)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- window-level model ----------------
   int     m_edge = 0, m_due = 0, m_acc = 0;
   int     m_c1 = 0, m_c2 = 0, m_c3 = 0;
   int     m_r1 = 0, m_r2 = 0, m_r3 = 0;
   longint m_amat = 0;
   bit     m_inflight = 1'b0, m_valid = 1'b0, m_drop = 1'b0;

   function automatic int classify(logic h1, logic m1, logic h2, logic m2);
      if (h1) return 1;
      if (m1 && h2) return 2;
      if (m1 && m2) return 3;
      return 0;
   endfunction

   task automatic model_step();
      bit     accept;
      int     k;
      longint tot;
      m_edge++;
      if (!rst_n || clear) begin
         m_acc = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
         m_inflight = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
         return;
      end
      accept = m_valid && stat_ready;
      k = classify(hit_l1, miss_l1, hit_l2, miss_l2);
      if (k != 0) begin
         m_acc++;
         if (k == 1) m_c1++;
         if (k == 2) m_c2++;
         if (k == 3) m_c3++;
         if (m_acc == WIN) begin
            if (m_inflight) begin
               m_drop = 1'b1;
            end else begin
               m_inflight = 1'b1;
               m_r1 = m_c1; m_r2 = m_c2; m_r3 = m_c3;
               tot = longint'(WIN) * 1 + longint'(m_c2 + m_c3) * 10 + longint'(m_c3) * 100;
               m_amat = (tot * 100) / WIN;
               if (m_amat > 64'hFFFFFF) m_amat = 64'hFFFFFF;
               m_due = m_edge + 42;
            end
            m_acc = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
         end
      end
      if (accept) begin
         m_valid = 1'b0;
         m_inflight = 1'b0;
      end else if (m_inflight && !m_valid && (m_edge == m_due)) begin
         m_valid = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (cmp_on) begin
         chk("cyc_valid", longint'(stat_valid), longint'(m_valid));
         chk("cyc_dropped", longint'(stat_dropped), longint'(m_drop));
         if (m_valid) begin
            chk("cyc_l1_hits", longint'(stat_l1_hits), longint'(m_r1));
            chk("cyc_l2_hits", longint'(stat_l2_hits), longint'(m_r2));
            chk("cyc_l2_misses", longint'(stat_l2_misses), longint'(m_r3));
            chk("cyc_amat", longint'(stat_amat_x100), m_amat);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic h1, input logic m1, input logic h2, input logic m2);
      @(negedge clk);
      hit_l1 = h1; miss_l1 = m1; hit_l2 = h2; miss_l2 = m2;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (stat_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (stat_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_wait: stat_valid=%b after %0d cycles, required 1", name, stat_valid, n);
      end
   endtask

   task automatic accept(input string name);
      @(negedge clk);
      stat_ready = 1'b1;
      @(negedge clk);
      stat_ready = 1'b0;
      chk({name, "_after_accept"}, longint'(stat_valid), 0);
   endtask

   task automatic check_result(input string name, input int l1, input int l2h,
                               input int l2m, input longint amat);
      chk({name, "_l1"}, longint'(stat_l1_hits), longint'(l1));
      chk({name, "_l2h"}, longint'(stat_l2_hits), longint'(l2h));
      chk({name, "_l2m"}, longint'(stat_l2_misses), longint'(l2m));
      chk({name, "_amat"}, longint'(stat_amat_x100), amat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "bench time limit");
   end

   // ---------------- directed tests ----------------
   initial begin
      int lat;
      rst_n = 1'b0; clear = 1'b0; stat_ready = 1'b0;
      hit_l1 = 1'b0; miss_l1 = 1'b0; hit_l2 = 1'b0; miss_l2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", longint'(stat_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_dropped", longint'(stat_dropped), 0);
      check_result("rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      cmp_on = 1'b1;

      // 1: eight L1 hits, latency 42 edges from the closing access
      repeat (WIN) drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      hit_l1 = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (stat_valid) break;
      end
      chk("t1_latency", longint'(lat), 42);
      @(negedge clk);
      check_result("t1", 8, 0, 0, 100);
      accept("t1");

      // 2: 4 L1 hits, 2 L2 hits, 2 L2 misses
      repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid("t2");
      check_result("t2", 4, 2, 2, 3100);
      accept("t2");

      // 3: eight L2 misses, result held for 50 cycles without ready
      repeat (WIN) drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid("t3");
      repeat (50) begin
         @(negedge clk);
         chk("t3_hold_valid", longint'(stat_valid), 1);
         chk("t3_hold_amat", longint'(stat_amat_x100), 11100);
      end
      check_result("t3", 0, 0, 8, 11100);
      accept("t3");

      // 4: second window closes while the first is still in flight
      repeat (WIN) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (WIN) drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid("t4");
      chk("t4_dropped", longint'(stat_dropped), 1);
      check_result("t4", 8, 0, 0, 100);
      accept("t4");
      repeat (60) @(negedge clk);
      chk("t4_no_second", longint'(stat_valid), 0);
      chk("t4_dropped_sticky", longint'(stat_dropped), 1);

      // 5: idle cycles, non-access strobes and double strobes interleaved
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid("t5");
      check_result("t5", 5, 2, 1, 1725);
      accept("t5");

      // 6: clear mid-divide with a concurrent access, then a fresh window
      repeat (WIN) drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("t6_busy_before", longint'(busy), 1);
      clear = 1'b1;
      hit_l1 = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      hit_l1 = 1'b0;
      chk("t6_busy_after_clear", longint'(busy), 0);
      chk("t6_valid_after_clear", longint'(stat_valid), 0);
      chk("t6_dropped_after_clear", longint'(stat_dropped), 0);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid("t6");
      check_result("t6", 6, 2, 0, 350);
      accept("t6");
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
